// File: rtl/booth_r4_seq_ctrl.sv
// booth_r4_seq_ctrl
//   Control sequencer for a radix-4 Booth multiplier datapath (M/A/Q
//   registers plus adder). It owns its iteration counter, handles signed and
//   unsigned operands, provides a start/busy/done handshake and drives
//   one-hot datapath strobes.
//
//   Parameters
//     WIDTH  operand width (even, >= 4)
//     CNT_W  iteration counter width (derived, leave at default)
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     start               multiply request, honoured only in IDLE
//     mode_signed         1 = two's complement, latched when start is accepted
//     q1, q0, q           recode triplet {Q[1],Q[0],Q[-1]} from the datapath
//     load_m / load_q     load multiplicand (clear A) / multiplier (clear Q[-1])
//     acc_en, sel_2m, sub adder control for the OP cycle
//     shift_en            arithmetic shift {A,Q,Q[-1]} right by 2
//     out_en, done        product on result bus, one-cycle completion pulse
//     busy                high in every state except IDLE
//     iter_cnt            current iteration index
//
//   Build option
//     BOOTH_SKIP_NOP_EN   when defined, a nop triplet (000/111) jumps straight
//                         from RECODE to SHIFT, saving one cycle per nop.

module booth_r4_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_signed,
  input  logic             q1,
  input  logic             q0,
  input  logic             q,
  output logic             load_m,
  output logic             load_q,
  output logic             acc_en,
  output logic             sel_2m,
  output logic             sub,
  output logic             shift_en,
  output logic             out_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_M   = 3'd1,
    S_LD_Q   = 3'd2,
    S_RECODE = 3'd3,
    S_OP     = 3'd4,
    S_SHIFT  = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  // Unsigned operands are zero-extended by two bits in the datapath, which
  // costs one extra radix-4 iteration.
  localparam logic [CNT_W-1:0] LAST_SIGNED   = CNT_W'(WIDTH/2 - 1);
  localparam logic [CNT_W-1:0] LAST_UNSIGNED = CNT_W'(WIDTH/2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode_signed;
  logic [CNT_W-1:0] r_iter_cnt;
  logic [CNT_W-1:0] w_last_idx;
  logic [2:0]       r_op;        // {acc_en, sel_2m, sub} decoded in RECODE
  logic [2:0]       w_dec;
  logic             w_last;

  // Booth radix-4 recode: returns {acc_en, sel_2m, sub}. Nops return all
  // zeros so sel_2m/sub can never be seen without acc_en.
  function automatic logic [2:0] recode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: recode = 3'b100;  // +M
      3'b011:         recode = 3'b110;  // +2M
      3'b100:         recode = 3'b111;  // -2M
      3'b101, 3'b110: recode = 3'b101;  // -M
      default:        recode = 3'b000;  // 000 / 111: nop
    endcase
  endfunction

  assign w_dec      = recode({q1, q0, q});
  assign w_last_idx = r_mode_signed ? LAST_SIGNED : LAST_UNSIGNED;
  assign w_last     = (r_iter_cnt == w_last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mode_signed <= 1'b0;
      r_iter_cnt    <= '0;
      r_op          <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_mode_signed <= mode_signed;
      end
      if (r_state == S_LD_M) begin
        r_iter_cnt <= '0;
      end else if (r_state == S_SHIFT && !w_last) begin
        r_iter_cnt <= r_iter_cnt + 1'b1;
      end
      // The triplet is only looked at here, so X on q1/q0/q elsewhere is harmless.
      if (r_state == S_RECODE) begin
        r_op <= w_dec;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    load_m      = 1'b0;
    load_q      = 1'b0;
    acc_en      = 1'b0;
    sel_2m      = 1'b0;
    sub         = 1'b0;
    shift_en    = 1'b0;
    out_en      = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LD_M;
      end
      S_LD_M: begin
        load_m      = 1'b1;
        w_state_nxt = S_LD_Q;
      end
      S_LD_Q: begin
        load_q      = 1'b1;
        w_state_nxt = S_RECODE;
      end
      S_RECODE: begin
`ifdef BOOTH_SKIP_NOP_EN
        w_state_nxt = w_dec[2] ? S_OP : S_SHIFT;
`else
        w_state_nxt = S_OP;
`endif
      end
      S_OP: begin
        acc_en      = r_op[2];
        sel_2m      = r_op[2] & r_op[1];
        sub         = r_op[2] & r_op[0];
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en    = 1'b1;
        w_state_nxt = w_last ? S_OUT : S_RECODE;
      end
      S_OUT: begin
        out_en      = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Testbench for booth_r4_seq_ctrl: a WIDTH=8 instance driven by directed
// operations and a WIDTH=16 instance run back-to-back with start held high.
// Stimulus pushes expected events into queues; one monitor on the falling
// edge pops and compares them as the DUTs present shift/done/probe events.

module tb_booth_r4_seq_ctrl;

  typedef struct {
    int         kind;   // 0 iteration at shift, 1 done, 2 busy probe, 3 idle-outputs probe
    logic [2:0] str;    // expected {acc_en, sel_2m, sub} for the iteration
    int         val;    // expected iter_cnt / busy
    int         cyc;    // cycle of done or probe
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  // WIDTH=8 instance
  logic       start0 = 1'b0, mode0 = 1'b0;
  logic       q1_0, q0_0, q_0;
  logic       load_m0, load_q0, acc_en0, sel_2m0, sub0, shift_en0, out_en0, busy0, done0;
  logic [2:0] iter0;
  logic [2:0] trips0 [8];
  int         tidx0 = 0;

  // WIDTH=16 instance
  logic       start1 = 1'b0, mode1 = 1'b1;
  logic       q1_1, q0_1, q_1;
  logic       load_m1, load_q1, acc_en1, sel_2m1, sub1, shift_en1, out_en1, busy1, done1;
  logic [3:0] iter1;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t pq[$];

  int         checks = 0, failures = 0;
  logic [2:0] acc_seen0 = 3'b000;
  int         sh1 = 0;
  logic       fin = 1'b0;

  assign {q1_0, q0_0, q_0} = trips0[tidx0[2:0]];
  assign {q1_1, q0_1, q_1} = 3'b010;

  booth_r4_seq_ctrl #(.WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode_signed(mode0),
    .q1(q1_0), .q0(q0_0), .q(q_0),
    .load_m(load_m0), .load_q(load_q0), .acc_en(acc_en0), .sel_2m(sel_2m0), .sub(sub0),
    .shift_en(shift_en0), .out_en(out_en0), .busy(busy0), .done(done0), .iter_cnt(iter0)
  );

  booth_r4_seq_ctrl #(.WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode_signed(mode1),
    .q1(q1_1), .q0(q0_1), .q(q_1),
    .load_m(load_m1), .load_q(load_q1), .acc_en(acc_en1), .sel_2m(sel_2m1), .sub(sub1),
    .shift_en(shift_en1), .out_en(out_en1), .busy(busy1), .done(done1), .iter_cnt(iter1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [2:0] str, input int val, input int c);
    exp_t e;
    e.kind = kind; e.str = str; e.val = val; e.cyc = c;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      e = pq.pop_front();
      if (e.kind == 2) begin
        chk("busy", int'(busy0), e.val);
      end else begin
        chk("idle_outputs0", int'({load_m0, load_q0, acc_en0, sel_2m0, sub0, shift_en0,
                                   out_en0, busy0, done0}), 0);
        chk("idle_iter0", int'(iter0), 0);
        chk("idle_outputs1", int'({load_m1, load_q1, acc_en1, sel_2m1, sub1, shift_en1,
                                   out_en1, busy1, done1}), 0);
        chk("idle_iter1", int'(iter1), 0);
      end
    end
    if (!rst) begin
      if (load_m0) begin
        tidx0     = 0;
        acc_seen0 = 3'b000;
      end
      if (acc_en0) acc_seen0 = {acc_en0, sel_2m0, sub0};
      if (shift_en0) begin
        if (sb0.size() == 0) chk("unexpected_shift0", 1, 0);
        else begin
          e = sb0.pop_front();
          chk("shift_order0", 0, e.kind);
          chk("strobes0", int'(acc_seen0), int'(e.str));
          chk("shift_iter0", int'(iter0), e.val);
        end
        acc_seen0 = 3'b000;
        tidx0++;
      end
      if (done0) begin
        if (sb0.size() == 0) chk("unexpected_done0", 1, 0);
        else begin
          e = sb0.pop_front();
          chk("done_order0", 1, e.kind);
          chk("done_cycle0", cyc, e.cyc);
          chk("out_en0", int'(out_en0), 1);
        end
      end
      if (shift_en1) sh1++;
      if (done1) begin
        if (sb1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e = sb1.pop_front();
          chk("done_cycle1", cyc, e.cyc);
          chk("shifts1", sh1, 8);
          chk("done_iter1", int'(iter1), 7);
        end
        sh1 = 0;
      end
    end
    if (fin) begin
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      chk("probes_drained", pq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_trips(input logic [2:0] a, b, c, d, e);
    trips0[0] = a; trips0[1] = b; trips0[2] = c; trips0[3] = d; trips0[4] = e;
    trips0[5] = 3'b000; trips0[6] = 3'b000; trips0[7] = 3'b000;
  endtask

  initial begin
    int t;
    int s;
    set_trips(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick();
    tick();
    rst = 1'b0;
    pq.push_back(mk(3, 3'b000, 0, cyc));
    tick();

    // Signed, +M every iteration; stray starts in cycles 3 and 15 must be ignored.
    set_trips(3'b010, 3'b010, 3'b010, 3'b010, 3'b000);
    start0 = 1'b1; mode0 = 1'b1; t = cyc;
    for (int i = 0; i < 4; i++) sb0.push_back(mk(0, 3'b100, i, 0));
    sb0.push_back(mk(1, 3'b000, 0, t + 15));
    pq.push_back(mk(2, 3'b000, 0, t));
    pq.push_back(mk(2, 3'b000, 1, t + 1));
    pq.push_back(mk(2, 3'b000, 1, t + 15));
    pq.push_back(mk(2, 3'b000, 0, t + 16));
    tick();
    start0 = 1'b0;
    wait_to(t + 3);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_to(t + 15);
    start0 = 1'b1;
    tick();

    // Unsigned, full recode mix; accepted in the first IDLE cycle.
    set_trips(3'b011, 3'b100, 3'b101, 3'b110, 3'b000);
    start0 = 1'b1; mode0 = 1'b0; t = cyc;
    sb0.push_back(mk(0, 3'b110, 0, 0));
    sb0.push_back(mk(0, 3'b111, 1, 0));
    sb0.push_back(mk(0, 3'b101, 2, 0));
    sb0.push_back(mk(0, 3'b101, 3, 0));
    sb0.push_back(mk(0, 3'b000, 4, 0));
    sb0.push_back(mk(1, 3'b000, 0, t + 18));
    tick();
    start0 = 1'b0; mode0 = 1'b1;    // must not disturb the latched mode
    wait_to(t + 19);

    // Reset during the second OP cycle.
    set_trips(3'b010, 3'b010, 3'b010, 3'b010, 3'b000);
    start0 = 1'b1; mode0 = 1'b1; t = cyc;
    sb0.push_back(mk(0, 3'b100, 0, 0));
    tick();
    start0 = 1'b0;
    wait_to(t + 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pq.push_back(mk(3, 3'b000, 0, cyc));
    tick();

    // Full operation after reset.
    set_trips(3'b001, 3'b010, 3'b011, 3'b111, 3'b000);
    start0 = 1'b1; mode0 = 1'b1; t = cyc;
    sb0.push_back(mk(0, 3'b100, 0, 0));
    sb0.push_back(mk(0, 3'b100, 1, 0));
    sb0.push_back(mk(0, 3'b110, 2, 0));
    sb0.push_back(mk(0, 3'b000, 3, 0));
    sb0.push_back(mk(1, 3'b000, 0, t + 15));
    tick();
    start0 = 1'b0;
    wait_to(t + 16);

    // Nop-heavy operation: 2-cycle nops when skipping is built in.
    set_trips(3'b000, 3'b111, 3'b010, 3'b000, 3'b000);
    start0 = 1'b1; mode0 = 1'b1; t = cyc;
    sb0.push_back(mk(0, 3'b000, 0, 0));
    sb0.push_back(mk(0, 3'b000, 1, 0));
    sb0.push_back(mk(0, 3'b100, 2, 0));
    sb0.push_back(mk(0, 3'b000, 3, 0));
`ifdef BOOTH_SKIP_NOP_EN
    sb0.push_back(mk(1, 3'b000, 0, t + 12));
`else
    sb0.push_back(mk(1, 3'b000, 0, t + 15));
`endif
    tick();
    start0 = 1'b0;
    wait_to(t + 16);

    // WIDTH=16 signed, start held high: two back-to-back operations.
    start1 = 1'b1; s = cyc;
    sb1.push_back(mk(1, 3'b000, 0, s + 27));
    sb1.push_back(mk(1, 3'b000, 0, s + 55));
    wait_to(s + 55);
    start1 = 1'b0;
    wait_to(s + 60);

    fin = 1'b1;
  end

endmodule
